// File: rtl/fifo_read_arbiter_if.sv
// Read-port bundle between the round-robin arbiter, the FIFO read side and
// the downstream consumers. The master modport is the arbiter's view.
interface fifo_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    req;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  rd_inc;
  logic [NUM_REQ-1:0]    gnt;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ID_WIDTH-1:0]   out_id;
  logic                  burst_done;

  modport master (
    input  req, fifo_empty, fifo_rdata,
    output rd_inc, gnt, out_valid, out_data, out_id, burst_done
  );

  modport slave (
    output req, fifo_empty, fifo_rdata,
    input  rd_inc, gnt, out_valid, out_data, out_id, burst_done
  );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing the FIFO read port among NUM_REQ consumers.
// A winner holds a one-hot grant for up to MAX_BURST pops; popped words come
// back one cycle later tagged with the owner's index.
//
// state | meaning
// IDLE  | no grant; picks the next requester after last winner when data exists
// BURST | grant held; pops while owner requests, FIFO has data, burst not full
module fifo_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst_n,
  fifo_read_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   owner;      // also serves as last_winner
  logic [CNT_W-1:0]      count;
  logic [NUM_REQ-1:0]    gnt_q;
  logic                  burst_done_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ID_WIDTH-1:0]   out_id_q;

  logic                  pick_found;
  logic [ID_WIDTH-1:0]   pick_id;
  logic [ID_WIDTH-1:0]   cand_id;
  int                    cand;
  logic                  pop;
  logic                  last_pop;
  logic                  exit_burst;

  // Round-robin search: first set request strictly after the last winner, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    cand_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand    = (int'(owner) + i) % NUM_REQ;
      cand_id = cand[ID_WIDTH-1:0];
      if (!pick_found && bus.req[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  // Pop decision is combinational so the pointer moves in the same cycle the
  // owner sees data; a burst ends on the first cycle without a pop or after
  // the final allowed pop, so the release shows up one cycle later.
  always_comb begin
    pop        = (state == BURST) && bus.req[owner] && !bus.fifo_empty &&
                 (count < CNT_W'(MAX_BURST));
    last_pop   = pop && (count == CNT_W'(MAX_BURST - 1));
    exit_burst = (state == BURST) && (!pop || last_pop);
  end

  // Grant/burst state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= ID_WIDTH'(NUM_REQ - 1);
      count        <= '0;
      gnt_q        <= '0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found && !bus.fifo_empty) begin
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id;
            owner   <= pick_id;
            count   <= '0;
            state   <= BURST;
          end
        end
        BURST: begin
          if (pop) begin
            count <= count + CNT_W'(1);
          end
          if (exit_burst) begin
            state        <= IDLE;
            gnt_q        <= '0;
            burst_done_q <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt_q <= '0;
        end
      endcase
    end
  end

  // Return path: capture the popped word and its owner at the pop edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= pop;
      if (pop) begin
        out_data_q <= bus.fifo_rdata;
        out_id_q   <= owner;
      end
    end
  end

  assign bus.rd_inc     = pop;
  assign bus.gnt        = gnt_q;
  assign bus.burst_done = burst_done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_id     = out_id_q;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Bench for fifo_read_arbiter: a FIFO model feeds the read port, a
// transaction-level reference predicts every output each cycle, and literal
// grant/length/data lists pin the expected sequence of each directed test.
module tb_fifo_read_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int MAXB    = 4;
  localparam int IDW     = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) bus ();

  fifo_read_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .MAX_BURST(MAXB), .ID_WIDTH(IDW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model
  logic [DW-1:0] fifo_q[$];
  bit            force_empty = 1'b0;
  event          fifo_ev;
  bit            rd_seen = 1'b0;

  // Reference: burst owner, pops so far, last delivered word
  bit            m_busy;
  int            m_owner;
  int            m_pops;
  bit            m_done;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  bit            m_pop;
  logic [DW-1:0] m_word;

  // Observation logs for the literal expectations
  int grant_log[$];
  int len_log[$];
  int data_log[$];
  int id_log[$];
  int obs_pops = 0;
  logic [NUM_REQ-1:0] prev_gnt = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_list(string name, int got[$], int exp[$]);
    chk({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, got[i], exp[i]);
  endfunction

  function automatic void m_reset();
    m_busy  = 1'b0;
    m_owner = NUM_REQ - 1;
    m_pops  = 0;
    m_done  = 1'b0;
    m_valid = 1'b0;
    m_data  = '0;
    m_id    = 0;
  endfunction

  function automatic bit exp_rd_inc();
    return m_busy && bus.req[m_owner[IDW-1:0]] && !bus.fifo_empty && (m_pops < MAXB);
  endfunction

  // A burst ends on the first cycle that passes without a pop, or once MAXB
  // words have gone; a new owner is the next requester after the previous one.
  function automatic void m_step(bit pop, logic [DW-1:0] word);
    m_valid = pop;
    if (pop) begin
      m_data = word;
      m_id   = m_owner;
    end
    if (m_busy) begin
      if (pop) m_pops++;
      m_done = !pop || (m_pops == MAXB);
      if (m_done) m_busy = 1'b0;
    end else begin
      m_done = 1'b0;
      if (bus.req != '0 && !bus.fifo_empty) begin
        for (int k = 1; k <= NUM_REQ; k++) begin
          int c;
          c = (m_owner + k) % NUM_REQ;
          if (bus.req[c[IDW-1:0]]) begin
            m_owner = c;
            break;
          end
        end
        m_busy = 1'b1;
        m_pops = 0;
      end
    end
  endfunction

  // Sole driver of the FIFO-side inputs
  initial begin
    forever begin
      @(fifo_ev);
      bus.fifo_empty = (fifo_q.size() == 0) || force_empty;
      bus.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end
  end

  // Reference update and FIFO pop on each edge
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        m_pop  = exp_rd_inc();
        m_word = bus.fifo_rdata;
        m_step(m_pop, m_word);
        #1;
        if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
        -> fifo_ev;
      end
    end
  end

  // Compare DUT against the reference and log bursts
  always @(negedge clk) begin
    logic [NUM_REQ-1:0] eg;
    eg = '0;
    if (m_busy) eg[m_owner[IDW-1:0]] = 1'b1;
    rd_seen = bus.rd_inc;
    chk("gnt", 32'(bus.gnt), 32'(eg));
    chk("rd_inc", 32'(bus.rd_inc), 32'(exp_rd_inc()));
    chk("burst_done", 32'(bus.burst_done), 32'(m_done));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    chk("out_data", 32'(bus.out_data), 32'(m_data));
    chk("out_id", 32'(bus.out_id), 32'(m_id));
    chk("rd_inc_safe", 32'(bus.rd_inc && (bus.fifo_empty || bus.gnt == '0)), 32'd0);
    if (bus.gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.gnt[i]) grant_log.push_back(i);
      obs_pops = bus.rd_inc ? 1 : 0;
    end else if (bus.rd_inc) begin
      obs_pops++;
    end
    if (bus.burst_done) len_log.push_back(obs_pops);
    if (bus.out_valid) begin
      data_log.push_back(int'(bus.out_data));
      id_log.push_back(int'(bus.out_id));
    end
    prev_gnt = bus.gnt;
  end

  task automatic clear_logs();
    grant_log.delete();
    len_log.delete();
    data_log.delete();
    id_log.delete();
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus.req     = '0;
    force_empty = 1'b0;
    fifo_q.delete();
    -> fifo_ev;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic push_words(int base, int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
    -> fifo_ev;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_pops(int n, int budget);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < budget) begin
      @(negedge clk);
      if (bus.rd_inc) seen++;
      cyc++;
    end
    if (seen < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_pops: got %0d pops expected %0d within %0d cycles", seen, n, budget);
    end
  endtask

  function automatic void expect_burst(string tag, int g[$], int l[$], int d0, int id[$]);
    int d[$];
    for (int i = 0; i < id.size(); i++) d.push_back((d0 + i) & 8'hFF);
    chk_list({tag, "_grants"}, grant_log, g);
    chk_list({tag, "_lens"}, len_log, l);
    chk_list({tag, "_data"}, data_log, d);
    chk_list({tag, "_ids"}, id_log, id);
  endfunction

  initial begin
    int ids[$];
    rst_n   = 1'b1;
    bus.req = '0;
    -> fifo_ev;
    #1;

    // 1: single requester, 6 words -> bursts of 4 then 2
    do_reset();
    chk("reset_gnt", 32'(bus.gnt), 32'd0);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_burst_done", 32'(bus.burst_done), 32'd0);
    bus.req = 4'b0001;
    push_words(8'hA0, 6);
    idle(20);
    expect_burst("t1", '{0, 0}, '{4, 2}, 8'hA0, '{0, 0, 0, 0, 0, 0});

    // 2: all requesting, rotation 0,1,2,3,0 with full bursts
    do_reset();
    bus.req = 4'b1111;
    push_words(8'h10, 20);
    idle(40);
    ids.delete();
    foreach (ids[i]) ids[i] = 0;
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < 4; k++) ids.push_back(b % 4);
    expect_burst("t2", '{0, 1, 2, 3, 0}, '{4, 4, 4, 4, 4}, 8'h10, ids);
    bus.req = '0;

    // 3: last winner 1, then req 0110 -> 2 then 1
    do_reset();
    bus.req = 4'b0010;
    push_words(8'h30, 1);
    idle(8);
    bus.req = 4'b0110;
    push_words(8'h31, 8);
    idle(30);
    expect_burst("t3", '{1, 2, 1}, '{1, 4, 4}, 8'h30, '{1, 2, 2, 2, 2, 1, 1, 1, 1});
    bus.req = '0;

    // 4: owner drops its request after 2 pops
    do_reset();
    bus.req = 4'b0011;
    push_words(8'h40, 8);
    wait_pops(2, 20);
    @(posedge clk);
    #2;
    bus.req = 4'b0010;
    idle(30);
    expect_burst("t4", '{0, 1, 1}, '{2, 4, 2}, 8'h40, '{0, 0, 1, 1, 1, 1, 1, 1});
    bus.req = '0;

    // 5: FIFO goes empty after 1 pop, then refills
    do_reset();
    bus.req = 4'b0001;
    push_words(8'h50, 6);
    wait_pops(1, 20);
    @(posedge clk);
    #2;
    force_empty = 1'b1;
    -> fifo_ev;
    idle(6);
    chk("t5_empty_gnt", 32'(bus.gnt), 32'd0);
    chk("t5_empty_rd_inc", 32'(bus.rd_inc), 32'd0);
    force_empty = 1'b0;
    -> fifo_ev;
    idle(25);
    expect_burst("t5", '{0, 0, 0}, '{1, 4, 1}, 8'h50, '{0, 0, 0, 0, 0, 0});
    bus.req = '0;

    // 6: reset during the third pop, then req 1001 goes to 0 first
    do_reset();
    bus.req = 4'b1000;
    push_words(8'h60, 6);
    wait_pops(2, 20);
    @(posedge clk);
    #2;
    chk("t6_pre_rd_inc", 32'(bus.rd_inc), 32'd1);
    chk("t6_pre_gnt", 32'(bus.gnt), 32'h8);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("t6_rst_rd_inc", 32'(bus.rd_inc), 32'd0);
    chk("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_out_data", 32'(bus.out_data), 32'd0);
    chk("t6_rst_out_id", 32'(bus.out_id), 32'd0);
    chk("t6_rst_burst_done", 32'(bus.burst_done), 32'd0);
    @(posedge clk);
    #2;
    bus.req = 4'b1001;
    rst_n   = 1'b1;
    clear_logs();
    idle(20);
    expect_burst("t6", '{0}, '{4}, 8'h62, '{0, 0, 0, 0});
    bus.req = '0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected end by 200000");
    $fatal(1, "timeout");
  end

endmodule
